// File: rtl/dvp_frame_capture_if.sv
// Bus bundle for the DVP capture stage: the raw camera pins on one side and
// the qualified pixel stream on the other. The capture block uses the slave
// view; the camera-side source and the pixel consumer use the master view.
interface dvp_frame_capture_if #(
  parameter int DATA_W = 8
);
  // Raw DVP pins shared by both cameras
  logic              VSYNC;
  logic              HREF;
  logic [DATA_W-1:0] D1;
  logic [DATA_W-1:0] D2;

  // Qualified pixel stream with frame/line markers and coordinates
  logic              pix_valid;
  logic [DATA_W-1:0] pix_d1;
  logic [DATA_W-1:0] pix_d2;
  logic              sof;
  logic              eol;
  logic              eof;
  logic [10:0]       x_cnt;
  logic [9:0]        y_cnt;

  modport master (
    output VSYNC, HREF, D1, D2,
    input  pix_valid, pix_d1, pix_d2, sof, eol, eof, x_cnt, y_cnt
  );

  modport slave (
    input  VSYNC, HREF, D1, D2,
    output pix_valid, pix_d1, pix_d2, sof, eol, eof, x_cnt, y_cnt
  );
endinterface

// File: rtl/dvp_frame_capture.sv
// DVP frame capture for the dual-camera RAW source. Registers the shared
// VSYNC/HREF and both byte buses, delineates frames and lines with a small
// FSM, and emits a pixel stream with sof/eol/eof markers and x/y position.
// Geometry is checked per line and per frame with sticky error flags, and
// completed frames are counted for the downstream HDR merge.
module dvp_frame_capture #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int DATA_W   = 8
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               capture_en,
  input  logic               err_clr,
  dvp_frame_capture_if.slave dvp,
  output logic [7:0]         frame_cnt,
  output logic               busy,
  output logic               err_line_len,
  output logic               err_frame_len
);

  localparam logic [10:0] H_FULL = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VS_HIGH   = 2'd1,
    WAIT_LINE = 2'd2,
    LINE      = 2'd3
  } state_t;

  state_t state;

  logic              vsync_p1;
  logic              vsync_p2;
  logic              href_p1;
  logic              href_p2;
  logic [DATA_W-1:0] d1_p1;
  logic [DATA_W-1:0] d2_p1;

  // Internal byte position within the line and line index within the frame
  logic [10:0] x_int;
  logic [9:0]  y_int;

  logic frame_start;
  logic href_rise;
  logic href_fall;
  logic take_byte;
  logic in_range;

  // Column counter stops at its maximum so a runaway HREF cannot wrap back
  // into the active window and re-emit pixels.
  function automatic logic [10:0] sat_inc_x(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc_y(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // ---- stage p1/p2: pin registers, second VSYNC/HREF copy for edges ----
  // Register the pins once, and keep a delayed copy of the syncs
  always_ff @(posedge pclk) begin
    if (reset) begin
      vsync_p1 <= 1'b0;
      vsync_p2 <= 1'b0;
      href_p1  <= 1'b0;
      href_p2  <= 1'b0;
      d1_p1    <= '0;
      d2_p1    <= '0;
    end else begin
      vsync_p1 <= dvp.VSYNC;
      vsync_p2 <= vsync_p1;
      href_p1  <= dvp.HREF;
      href_p2  <= href_p1;
      d1_p1    <= dvp.D1;
      d2_p1    <= dvp.D2;
    end
  end

  assign frame_start = vsync_p1 & ~vsync_p2;
  assign href_rise   = href_p1 & ~href_p2;
  assign href_fall   = ~href_p1 & href_p2;

  // The byte that raises HREF is already the first byte of the line, so it
  // is taken in WAIT_LINE on the same cycle the FSM moves into LINE. A frame
  // start always takes priority and aborts whatever line is in progress.
  assign take_byte = ~frame_start &
                     (((state == WAIT_LINE) & href_rise) |
                      ((state == LINE) & href_p1));
  assign in_range  = (x_int < H_FULL);

  // ---- stage p3: frame/line FSM, registered pixel stream and status ----
  // Frame/line sequencing with registered pixel, marker and status outputs
  always_ff @(posedge pclk) begin
    if (reset) begin
      state         <= IDLE;
      x_int         <= '0;
      y_int         <= '0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      dvp.pix_valid <= 1'b0;
      dvp.pix_d1    <= '0;
      dvp.pix_d2    <= '0;
      dvp.sof       <= 1'b0;
      dvp.eol       <= 1'b0;
      dvp.eof       <= 1'b0;
      dvp.x_cnt     <= '0;
      dvp.y_cnt     <= '0;
    end else begin
      dvp.pix_valid <= 1'b0;
      dvp.sof       <= 1'b0;
      dvp.eol       <= 1'b0;
      dvp.eof       <= 1'b0;

      // Clear first; any error raised further down this cycle overrides it
      if (err_clr) begin
        err_line_len  <= 1'b0;
        err_frame_len <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_start && capture_en) begin
            state <= VS_HIGH;
            busy  <= 1'b1;
            x_int <= '0;
            y_int <= '0;
          end
        end

        VS_HIGH: begin
          // HREF activity during the VSYNC pulse is ignored without error
          if (!vsync_p1) begin
            state <= WAIT_LINE;
          end
        end

        WAIT_LINE, LINE: begin
          if (frame_start) begin
            // New frame before this one delivered all its lines: drop it
            err_frame_len <= 1'b1;
            x_int         <= '0;
            y_int         <= '0;
            if (capture_en) begin
              state <= VS_HIGH;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (state == WAIT_LINE) begin
            if (href_rise) begin
              state <= LINE;
            end
          end else if (href_fall) begin
            x_int <= '0;
            y_int <= sat_inc_y(y_int);
            if (x_int != H_FULL) begin
              err_line_len <= 1'b1;
            end
            if (y_int == V_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              // A full last line already counted the frame alongside eof;
              // a short last line never reaches eof, so count it here.
              if (x_int < H_FULL) begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end else begin
              state <= WAIT_LINE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (take_byte) begin
        x_int <= sat_inc_x(x_int);
        if (in_range) begin
          dvp.pix_valid <= 1'b1;
          dvp.pix_d1    <= d1_p1;
          dvp.pix_d2    <= d2_p1;
          dvp.x_cnt     <= x_int;
          dvp.y_cnt     <= y_int;
          dvp.sof       <= (x_int == 11'd0) && (y_int == 10'd0);
          dvp.eol       <= (x_int == H_LAST);
          if ((x_int == H_LAST) && (y_int == V_LAST)) begin
            dvp.eof   <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end else begin
          // Bytes past the active width are dropped and flag the line
          err_line_len <= 1'b1;
        end
      end
    end
  end

endmodule
